bridge_tx: RTL
==============

BRIDGE_TX -- requirements
Module: bridge_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_i  input  16  read-data word to report to host.
REQ-005 SHALL have port valid_i  input  1  data_i valid; request to send one response.
REQ-006 SHALL have port ready_o  output  1  high when idle and able to accept a word.
REQ-007 SHALL have port txd  output  1  UART serial line to host, 8N1, idle high.

Function
REQ-008 SHALL accept a word on any rising edge where valid_i && ready_o; SHALL register data_i on that edge.
REQ-009 SHALL ignore valid_i while ready_o is low; data_i changes while busy SHALL NOT affect the message in flight.
REQ-010 SHALL transmit, per accepted word, exactly 7 bytes in order: 0x4D ('M'), four upper-case ASCII hex digits of the word (MSN first), 0x0D, 0x0A.
REQ-011 SHALL encode nibble n as 0x30+n for n<=9 and 0x41+(n-10) for n>=10.
REQ-012 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLOCKS_PER_BAUD cycles.
REQ-013 SHALL drive txd low (start bit of byte 0) beginning the cycle after the accepting edge: latency 1 cycle.
REQ-014 SHALL start each subsequent byte's start bit immediately after the previous stop bit's last cycle; no idle gap inside a message.
REQ-015 SHALL deassert ready_o from the cycle after acceptance until exactly 70*CLOCKS_PER_BAUD cycles later; ready_o SHALL be high on the first cycle after the final stop bit.
REQ-016 SHALL allow back-to-back messages: a word accepted on the first ready cycle SHALL start its start bit the following cycle, with txd high in between for exactly that one cycle.
REQ-017 SHALL implement top-level FSM states IDLE (ready_o=1, txd=1) and SEND (byte index 0..6); IDLE->SEND on acceptance; SEND advances index on byte-done; SEND->IDLE after byte 6 done.
REQ-018 SHALL size the baud counter as $clog2(CLOCKS_PER_BAUD) bits; it SHALL wrap to 0 after CLOCKS_PER_BAUD-1 with no off-by-one drift over 70 bits.

Reset
REQ-019 SHALL, on rst high at a clock edge, enter IDLE next cycle: ready_o=1, txd=1, counters and byte index 0, regardless of mid-frame position.
REQ-020 SHALL, when rst and valid_i are high on the same edge, give rst priority; no word accepted.
REQ-021 SHALL NOT emit a partial byte after reset; a truncated frame is the host's concern.

Structure
REQ-022 SHALL place constants PREFIX_CHAR=0x4D, CR_CHAR=0x0D, LF_CHAR=0x0A, MSG_LEN=7 and a nibble-to-ASCII function in shared package bridge_pkg.
REQ-023 SHALL instantiate one sub-module uart_tx (ports clk, rst, data_i[7:0], start_i, done_o, txd; parameter CLOCKS_PER_BAUD) performing single-byte 8N1 framing; bridge_tx sequences bytes into it.
REQ-024 SHALL register txd (no combinational path from data_i or valid_i to txd).

Verification (CLOCKS_PER_BAUD=4 unless stated)
REQ-025 SHALL verify: accept 0x1A2F -> txd decodes 4D 31 41 32 46 0D 0A; txd low 1 cycle after accept; ready_o high again exactly 280 cycles after txd first falls.
REQ-026 SHALL verify: 0x0000 then 0xFFFF with valid_i held high -> "M0000\r\n" then "MFFFF\r\n"; exactly one idle-high cycle between messages.
REQ-027 SHALL verify: valid_i pulsed with 0xBEEF at cycle 50 of a 0x1234 message -> only "M1234\r\n" sent; 0xBEEF never appears.
REQ-028 SHALL verify: rst asserted at cycle 100 of a message -> next cycle txd=1, ready_o=1; new word 0x00C3 then yields clean "M00C3\r\n".
REQ-029 SHALL verify: rst and valid_i (0x5555) on same edge -> no transmission; txd stays high for 300 cycles.
REQ-030 SHALL verify: CLOCKS_PER_BAUD=2 and 868 each send 0xA5A5 -> "MA5A5\r\n" with every bit exactly CLOCKS_PER_BAUD cycles wide.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared constants, types and ASCII helpers for the UART read-data bridge.
package bridge_pkg;

  localparam logic [7:0] PREFIX_CHAR = 8'h4D;
  localparam logic [7:0] CR_CHAR     = 8'h0D;
  localparam logic [7:0] LF_CHAR     = 8'h0A;
  localparam int         MSG_LEN     = 7;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_SEND = 1'b1
  } bridge_state_e;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_e;

  // Debug view of both state machines, for binding checkers.
  typedef struct packed {
    bridge_state_e bridge_state;
    logic [2:0]    byte_idx;
    uart_state_e   uart_state;
  } dbg_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  // Byte idx of the message "M" hhhh CR LF for word w.
  function automatic logic [7:0] msg_byte(input logic [15:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return PREFIX_CHAR;
      3'd1:    return nibble_to_ascii(w[15:12]);
      3'd2:    return nibble_to_ascii(w[11:8]);
      3'd3:    return nibble_to_ascii(w[7:4]);
      3'd4:    return nibble_to_ascii(w[3:0]);
      3'd5:    return CR_CHAR;
      default: return LF_CHAR;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Single-byte 8N1 serializer; a start_i seen on the final stop-bit cycle chains the next byte with no gap.
import bridge_pkg::*;

module uart_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        start_i,
  output logic        done_o,
  output logic        txd,
  output uart_state_e state_o
);

  localparam int                CNT_W    = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_o  = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != U_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      U_IDLE: begin
        if (start_i) begin
          state_d = U_START;
          shift_d = data_i;
          cnt_d   = '0;
        end
      end
      U_START: begin
        if (bit_end) begin
          state_d = U_DATA;
          bit_d   = 3'd0;
        end
      end
      U_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = U_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      U_STOP: begin
        if (bit_end) begin
          done_o = 1'b1;
          if (start_i) begin
            state_d = U_START;
            shift_d = data_i;
          end else begin
            state_d = U_IDLE;
          end
        end
      end
      default: state_d = U_IDLE;
    endcase

    // The line level is decided from the next state so txd leaves a flop.
    case (state_d)
      U_START: txd_d = 1'b0;
      U_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign txd     = txd_q;
  assign state_o = state_q;

endmodule

// File: rtl/bridge_tx.sv
// Reports a 16-bit read word to the host as "M" + four hex digits + CR LF over 8N1 UART.
import bridge_pkg::*;

module bridge_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        txd,
  output dbg_t        dbg_o
);

  // Handshake: a word is taken on any rising edge with valid_i && ready_o;
  // ready_o stays low for the whole 7-byte message and valid_i is ignored meanwhile.

  bridge_state_e state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   word_q, word_d;
  logic          u_start;
  logic [7:0]    u_byte;
  logic          u_done;
  uart_state_e   u_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= B_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    u_start = 1'b0;
    u_byte  = msg_byte(word_q, idx_q);

    case (state_q)
      B_IDLE: begin
        if (valid_i) begin
          state_d = B_SEND;
          idx_d   = 3'd0;
          word_d  = data_i;
          u_start = 1'b1;
          u_byte  = PREFIX_CHAR;
        end
      end
      B_SEND: begin
        if (u_done) begin
          if (idx_q == 3'(MSG_LEN - 1)) begin
            state_d = B_IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d   = idx_q + 3'd1;
            u_start = 1'b1;
            u_byte  = msg_byte(word_q, idx_q + 3'd1);
          end
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .data_i  (u_byte),
    .start_i (u_start),
    .done_o  (u_done),
    .txd     (txd),
    .state_o (u_state)
  );

  assign ready_o = (state_q == B_IDLE);
  assign dbg_o   = '{bridge_state: state_q, byte_idx: idx_q, uart_state: u_state};

endmodule
